// File: rtl/updown_count_decoder.sv
// rtl/updown_count_decoder.sv - decodes a sampled up/down count bus into steps, events and extended position
// Optional feature macro: STALL_DETECT_EN (hold-run stall detection; stall tied 0 when undefined).
module updown_count_decoder #(
    parameter int CW        = 5,
    parameter int PW        = 16,
    parameter int ERR_LIM   = 3,
    parameter int STALL_LIM = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] count_in,
    input  logic          valid_in,
    input  logic          clr,
    output logic          locked,
    output logic          fault,
    output logic          dir,
    output logic          step_up,
    output logic          step_dn,
    output logic          wrap,
    output logic          reset_seen,
    output logic          preset_seen,
    output logic          err,
    output logic [PW-1:0] position,
    output logic [7:0]    err_total,
    output logic          stall
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_prev;
    logic [3:0]    r_err_run;
    logic          r_locked;
    logic          r_fault;
    logic          r_dir;
    logic          r_step_up;
    logic          r_step_dn;
    logic          r_wrap;
    logic          r_reset_seen;
    logic          r_preset_seen;
    logic          r_err;
    logic [PW-1:0] r_position;
    logic [7:0]    r_err_total;

    logic [CW-1:0] w_all_ones;
    logic [CW-1:0] w_diff;
    logic [3:0]    w_err_run_inc;
    logic          w_clear;

    assign w_all_ones    = {CW{1'b1}};
    assign w_diff        = count_in - r_prev;
    assign w_err_run_inc = r_err_run + 4'd1;
    assign w_clear       = !reset_n || clr;

    always_ff @(posedge clk) begin
        // Event pulses are single-cycle: default low, raised only by a decoded sample.
        r_step_up     <= 1'b0;
        r_step_dn     <= 1'b0;
        r_wrap        <= 1'b0;
        r_reset_seen  <= 1'b0;
        r_preset_seen <= 1'b0;
        r_err         <= 1'b0;
        if (w_clear) begin
            r_state     <= ST_UNLOCKED;
            r_prev      <= '0;
            r_err_run   <= '0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_dir       <= 1'b0;
            r_position  <= '0;
            r_err_total <= '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (valid_in) begin
                        r_prev     <= count_in;
                        r_position <= PW'(count_in);
                        r_locked   <= 1'b1;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (valid_in) begin
                        r_prev <= count_in;
                        if (w_diff == CW'(1)) begin
                            r_step_up  <= 1'b1;
                            r_dir      <= 1'b1;
                            r_position <= r_position + PW'(1);
                            r_wrap     <= (r_prev == w_all_ones);
                            r_err_run  <= '0;
                        end else if (w_diff == w_all_ones) begin
                            r_step_dn  <= 1'b1;
                            r_dir      <= 1'b0;
                            r_position <= r_position - PW'(1);
                            r_wrap     <= (r_prev == '0);
                            r_err_run  <= '0;
                        end else if (w_diff == '0) begin
                            r_err_run <= '0;
                        end else if (count_in == '0) begin
                            r_reset_seen <= 1'b1;
                            r_position   <= '0;
                            r_err_run    <= '0;
                        end else if (count_in == w_all_ones) begin
                            r_preset_seen <= 1'b1;
                            r_position    <= PW'(w_all_ones);
                            r_err_run     <= '0;
                        end else begin
                            r_err       <= 1'b1;
                            r_err_total <= (r_err_total == 8'hFF) ? r_err_total : r_err_total + 8'd1;
                            r_err_run   <= w_err_run_inc;
                            if (w_err_run_inc >= 4'(ERR_LIM)) begin
                                r_state  <= ST_FAULT;
                                r_locked <= 1'b0;
                                r_fault  <= 1'b1;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    r_locked <= 1'b0;
                    r_fault  <= 1'b1;
                end
                default: begin
                    r_state  <= ST_UNLOCKED;
                    r_locked <= 1'b0;
                    r_fault  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_DETECT_EN
    localparam int HW = $clog2(STALL_LIM + 1);

    logic [HW-1:0] r_hold_run;
    logic          r_stall;

    // The run saturates at STALL_LIM so long holds cannot roll the counter back below the limit.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_hold_run <= '0;
            r_stall    <= 1'b0;
        end else if (r_state == ST_LOCKED && valid_in) begin
            if (w_diff == '0) begin
                if (r_hold_run < HW'(STALL_LIM)) begin
                    r_hold_run <= r_hold_run + HW'(1);
                end
                r_stall <= ((int'(r_hold_run) + 1) >= STALL_LIM);
            end else begin
                r_hold_run <= '0;
                r_stall    <= 1'b0;
            end
        end else if (r_state != ST_LOCKED) begin
            r_hold_run <= '0;
            r_stall    <= 1'b0;
        end
    end

    assign stall = r_stall;
`else
    assign stall = 1'b0;
`endif

    assign locked      = r_locked;
    assign fault       = r_fault;
    assign dir         = r_dir;
    assign step_up     = r_step_up;
    assign step_dn     = r_step_dn;
    assign wrap        = r_wrap;
    assign reset_seen  = r_reset_seen;
    assign preset_seen = r_preset_seen;
    assign err         = r_err;
    assign position    = r_position;
    assign err_total   = r_err_total;

endmodule

// File: tb/tb_updown_count_decoder.sv
// tb/tb_updown_count_decoder.sv - directed scoreboard bench for updown_count_decoder
module tb_updown_count_decoder;

`ifdef STALL_DETECT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  count_in;
    logic        valid_in;
    logic        clr;
    logic        locked, fault, dir, step_up, step_dn, wrap;
    logic        reset_seen, preset_seen, err, stall;
    logic [15:0] position;
    logic [7:0]  err_total;

    always #5 clk = ~clk;

    updown_count_decoder #(.CW(5), .PW(16), .ERR_LIM(3), .STALL_LIM(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .count_in    (count_in),
        .valid_in    (valid_in),
        .clr         (clr),
        .locked      (locked),
        .fault       (fault),
        .dir         (dir),
        .step_up     (step_up),
        .step_dn     (step_dn),
        .wrap        (wrap),
        .reset_seen  (reset_seen),
        .preset_seen (preset_seen),
        .err         (err),
        .position    (position),
        .err_total   (err_total),
        .stall       (stall)
    );

    typedef struct packed {
        logic        locked;
        logic        fault;
        logic        dir;
        logic        step_up;
        logic        step_dn;
        logic        wrap;
        logic        reset_seen;
        logic        preset_seen;
        logic        err;
        logic        stall;
        logic [15:0] position;
        logic [7:0]  err_total;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic lk, input logic f, input logic d,
                                input logic su, input logic sd, input logic wr,
                                input logic rs, input logic ps, input logic er,
                                input int pos, input int et);
        exp_t e;
        e.locked      = lk;
        e.fault       = f;
        e.dir         = d;
        e.step_up     = su;
        e.step_dn     = sd;
        e.wrap        = wr;
        e.reset_seen  = rs;
        e.preset_seen = ps;
        e.err         = er;
        e.stall       = 1'b0;
        e.position    = 16'(pos);
        e.err_total   = 8'(et);
        return e;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, ex);
        end
    endtask

    task automatic apply(input string tag, input logic rn, input logic cl,
                         input logic v, input logic [4:0] c, input exp_t e);
        exp_t x;
        reset_n  = rn;
        clr      = cl;
        valid_in = v;
        count_in = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk(tag, "locked",      16'(locked),      16'(x.locked));
        chk(tag, "fault",       16'(fault),       16'(x.fault));
        chk(tag, "dir",         16'(dir),         16'(x.dir));
        chk(tag, "step_up",     16'(step_up),     16'(x.step_up));
        chk(tag, "step_dn",     16'(step_dn),     16'(x.step_dn));
        chk(tag, "wrap",        16'(wrap),        16'(x.wrap));
        chk(tag, "reset_seen",  16'(reset_seen),  16'(x.reset_seen));
        chk(tag, "preset_seen", 16'(preset_seen), 16'(x.preset_seen));
        chk(tag, "err",         16'(err),         16'(x.err));
        chk(tag, "stall",       16'(stall),       16'(x.stall));
        chk(tag, "position",    position,         x.position);
        chk(tag, "err_total",   16'(err_total),   16'(x.err_total));
    endtask

    task automatic smp(input string tag, input logic [4:0] c, input exp_t e);
        apply(tag, 1'b1, 1'b0, 1'b1, c, e);
    endtask

    task automatic do_clr(input string tag);
        apply(tag, 1'b1, 1'b1, 1'b0, 5'd0, mk(0,0,0, 0,0,0, 0,0,0, 0, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // reset state and simple up counting
        apply("t1_reset", 1'b0, 1'b0, 1'b0, 5'd0, mk(0,0,0, 0,0,0, 0,0,0, 0, 0));
        smp("t1_s3", 5'd3, mk(1,0,0, 0,0,0, 0,0,0, 3, 0));
        smp("t1_s4", 5'd4, mk(1,0,1, 1,0,0, 0,0,0, 4, 0));
        smp("t1_s5", 5'd5, mk(1,0,1, 1,0,0, 0,0,0, 5, 0));
        apply("t1_idle", 1'b1, 1'b0, 1'b0, 5'd6, mk(1,0,1, 0,0,0, 0,0,0, 5, 0));
        // down counting through zero, extended position wraps below 0
        do_clr("t2_clr");
        smp("t2_s1",  5'd1,  mk(1,0,0, 0,0,0, 0,0,0, 1, 0));
        smp("t2_s0",  5'd0,  mk(1,0,0, 0,1,0, 0,0,0, 0, 0));
        smp("t2_s31", 5'd31, mk(1,0,0, 0,1,1, 0,0,0, 65535, 0));
        smp("t2_s30", 5'd30, mk(1,0,0, 0,1,0, 0,0,0, 65534, 0));
        // reset / preset jumps, hold, and counter reset from all-ones seen as step
        do_clr("t3_clr_a");
        smp("t3_s10", 5'd10, mk(1,0,0, 0,0,0, 0,0,0, 10, 0));
        smp("t3_s0",  5'd0,  mk(1,0,0, 0,0,0, 1,0,0, 0, 0));
        do_clr("t3_clr_b");
        smp("t3_s20", 5'd20, mk(1,0,0, 0,0,0, 0,0,0, 20, 0));
        smp("t3_s31", 5'd31, mk(1,0,0, 0,0,0, 0,1,0, 31, 0));
        smp("t3_hold", 5'd31, mk(1,0,0, 0,0,0, 0,0,0, 31, 0));
        smp("t3_wrap0", 5'd0, mk(1,0,1, 1,0,1, 0,0,0, 32, 0));
        // a legal step between errors restarts the error run
        do_clr("t4a_clr");
        smp("t4a_s5",  5'd5,  mk(1,0,0, 0,0,0, 0,0,0, 5, 0));
        smp("t4a_s9",  5'd9,  mk(1,0,0, 0,0,0, 0,0,1, 5, 1));
        smp("t4a_s10", 5'd10, mk(1,0,1, 1,0,0, 0,0,0, 6, 1));
        smp("t4a_s15", 5'd15, mk(1,0,1, 0,0,0, 0,0,1, 6, 2));
        smp("t4a_s20", 5'd20, mk(1,0,1, 0,0,0, 0,0,1, 6, 3));
        // three consecutive illegal jumps force FAULT; clr recovers
        do_clr("t4_clr");
        smp("t4_s5",  5'd5,  mk(1,0,0, 0,0,0, 0,0,0, 5, 0));
        smp("t4_s9",  5'd9,  mk(1,0,0, 0,0,0, 0,0,1, 5, 1));
        smp("t4_s14", 5'd14, mk(1,0,0, 0,0,0, 0,0,1, 5, 2));
        smp("t4_s19", 5'd19, mk(0,1,0, 0,0,0, 0,0,1, 5, 3));
        smp("t4_s20", 5'd20, mk(0,1,0, 0,0,0, 0,0,0, 5, 3));
        smp("t4_s0",  5'd0,  mk(0,1,0, 0,0,0, 0,0,0, 5, 3));
        do_clr("t4_clr_out");
        // clr beats a simultaneous valid sample
        apply("t5_clr_s7", 1'b1, 1'b1, 1'b1, 5'd7, mk(0,0,0, 0,0,0, 0,0,0, 0, 0));
        apply("t5_idle", 1'b1, 1'b0, 1'b0, 5'd7, mk(0,0,0, 0,0,0, 0,0,0, 0, 0));
        smp("t5_s8", 5'd8, mk(1,0,0, 0,0,0, 0,0,0, 8, 0));
        // reset_n beats clr and an otherwise-step sample
        apply("t5_rst", 1'b0, 1'b1, 1'b1, 5'd9, mk(0,0,0, 0,0,0, 0,0,0, 0, 0));
        // hold run: stall only in the STALL_DETECT_EN build
        smp("t6_s12", 5'd12, mk(1,0,0, 0,0,0, 0,0,0, 12, 0));
        for (int k = 1; k <= 8; k++) begin
            e = mk(1,0,0, 0,0,0, 0,0,0, 12, 0);
            e.stall = STALL_ON && (k >= 8);
            smp($sformatf("t6_hold%0d", k), 5'd12, e);
        end
        smp("t6_s13", 5'd13, mk(1,0,1, 1,0,0, 0,0,0, 13, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
